// File: rtl/ser_out_shiftreg_if.sv
// Purpose : bundles the parallel request side and the serial pin side of ser_out_shiftreg.
// Latency : none, wires only.
// Backpressure: none; busy/frame_done report progress and force_req requests are never lost.
//
// Signals:
//   data_in      [WIDTH] value to present on the external register outputs
//   force_req           single-cycle request for a frame even if data_in is unchanged
//   ser_out_clk         external shift clock
//   ser_out_dat         external serial data, MSB first
//   ser_out_rclk        external storage-register latch strobe
//   busy                high while a frame is in progress
//   frame_done          single-cycle pulse on the last latch cycle
// The request input is called force_req because "force" is a reserved word.
interface ser_out_shiftreg_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_in;
    logic             force_req;
    logic             ser_out_clk;
    logic             ser_out_dat;
    logic             ser_out_rclk;
    logic             busy;
    logic             frame_done;

    // Master: the logic that owns the parallel value.
    modport master (
        output data_in,
        output force_req,
        input  ser_out_clk,
        input  ser_out_dat,
        input  ser_out_rclk,
        input  busy,
        input  frame_done
    );

    // Slave: the serializer itself.
    modport slave (
        input  data_in,
        input  force_req,
        output ser_out_clk,
        output ser_out_dat,
        output ser_out_rclk,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/ser_out_shiftreg.sv
// Purpose : serializes data_in into an external shift register (clk/dat/rclk), MSB first.
// Latency : frame starts the cycle after a trigger in IDLE; (2*WIDTH+1)*CLK_DIV cycles to IDLE.
// Backpressure: none; triggers while busy are folded into one pending frame, data changes
//               are picked up by the compare once the block is back in IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   bus          ser_out_shiftreg_if.slave (data_in, force_req in; serial pins, busy,
//                frame_done out)
// Build option: define SER_OUT_REFRESH_EN to add the periodic refresh counter (period
// REFRESH clk cycles). Without it REFRESH is not used and frames start only on pending,
// force_req or a change of data_in.
module ser_out_shiftreg #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4,
    parameter int REFRESH = 65536
) (
    input  logic                clk,
    input  logic                reset,
    ser_out_shiftreg_if.slave   bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT_LO = 2'd1;
    localparam logic [1:0] SHIFT_HI = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    localparam int             BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]     HP_LOAD = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0]  BIT_TOP = BW'(WIDTH - 1);

    logic [1:0]       state;
    logic [7:0]       hp_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] last_sent;
    logic             pending;
    logic             refresh_wrap;
    logic             start;
    logic             hp_zero;

`ifdef SER_OUT_REFRESH_EN
    localparam int              RW          = (REFRESH > 2) ? $clog2(REFRESH) : 1;
    localparam logic [RW-1:0]   REFRESH_TOP = RW'(REFRESH - 1);

    logic [RW-1:0] refresh_cnt;

    // Free-running; the wrap cycle is the refresh request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign refresh_wrap = (refresh_cnt == REFRESH_TOP);
`else
    // No refresh timer: constant 0 for every legal REFRESH (2..2^24).
    assign refresh_wrap = (REFRESH < 2);
`endif

    assign hp_zero = (hp_cnt == 8'd0);

    // All trigger sources collapse into one start, so simultaneous triggers give one frame.
    assign start = (state == IDLE) &&
                   (pending || bus.force_req || refresh_wrap || (bus.data_in != last_sent));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hp_cnt    <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            last_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift     <= bus.data_in;
                        last_sent <= bus.data_in;
                        bit_cnt   <= BIT_TOP;
                        hp_cnt    <= HP_LOAD;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (hp_zero) begin
                        hp_cnt <= HP_LOAD;
                        state  <= SHIFT_HI;
                    end else begin
                        hp_cnt <= hp_cnt - 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (hp_zero) begin
                        hp_cnt <= HP_LOAD;
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                            state   <= SHIFT_LO;
                        end else begin
                            state   <= LATCH;
                        end
                    end else begin
                        hp_cnt <= hp_cnt - 8'd1;
                    end
                end
                LATCH: begin
                    if (hp_zero) begin
                        hp_cnt <= '0;
                        state  <= IDLE;
                    end else begin
                        hp_cnt <= hp_cnt - 8'd1;
                    end
                end
                default: begin
                    hp_cnt <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Set by reset so the first frame after release goes out unconditionally.
    // A start consumes it; a force or refresh arriving mid-frame re-arms it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b1;
        end else if (start) begin
            pending <= 1'b0;
        end else if (bus.force_req || refresh_wrap) begin
            pending <= 1'b1;
        end
    end

    // Pins decode straight from state so reset forces them low without waiting for an edge.
    // bit_cnt only moves on the HI->LO step, so dat is stable across the whole bit.
    assign bus.busy         = (state != IDLE);
    assign bus.ser_out_clk  = (state == SHIFT_HI);
    assign bus.ser_out_rclk = (state == LATCH);
    assign bus.ser_out_dat  = ((state == SHIFT_LO) || (state == SHIFT_HI)) && shift[bit_cnt];
    assign bus.frame_done   = (state == LATCH) && hp_zero;

endmodule

// File: doc/ser_out_shiftreg.md
SER_OUT_SHIFTREG -- requirements
Module: ser_out_shiftreg

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of serial output bits per frame (2..64).
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per serial half-period (1..255).
REQ-003 SHALL have parameter REFRESH, default 65536: clk cycles between forced refresh frames (2..2^24).
REQ-004 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  input  WIDTH  parallel value to present on the external register outputs.
REQ-007 SHALL have port force  input  1  single-cycle request for a frame even when data_in is unchanged.
REQ-008 SHALL have port ser_out_clk  output  1  external shift clock.
REQ-009 SHALL have port ser_out_dat  output  1  external serial data.
REQ-010 SHALL have port ser_out_rclk  output  1  external storage-register latch strobe.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port frame_done  output  1  single-cycle pulse on the last LATCH cycle.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT_LO, SHIFT_HI and LATCH.
REQ-014 In IDLE, a frame SHALL start when pending, force, refresh expiry or (data_in != last_sent) is true; with more than one of these true in the same cycle, exactly one frame SHALL start.
REQ-015 On the start cycle the block SHALL snapshot data_in into shift and last_sent, clear pending, set bit counter to WIDTH-1 and enter SHIFT_LO on the next cycle.
REQ-016 SHIFT_LO SHALL last CLK_DIV cycles with ser_out_clk=0 and ser_out_dat=shift[bit], MSB first.
REQ-017 SHIFT_HI SHALL last CLK_DIV cycles with ser_out_clk=1 and ser_out_dat held.
REQ-018 After SHIFT_HI, the block SHALL go to SHIFT_LO with the bit counter decremented if bit>0; otherwise it SHALL go to LATCH.
REQ-019 LATCH SHALL last CLK_DIV cycles with ser_out_rclk=1 and ser_out_clk=0, then return to IDLE.
REQ-020 Frame length from the first SHIFT_LO cycle to IDLE SHALL be (2*WIDTH+1)*CLK_DIV cycles.
REQ-021 busy SHALL be high in every non-IDLE state.
REQ-022 force asserted while busy SHALL set pending, which causes exactly one further frame; data_in changes while busy SHALL be ignored until IDLE, where the compare then triggers.
REQ-023 The half-period counter SHALL be 8 bits wide, load CLK_DIV-1 on each state entry and advance at zero.
REQ-024 The refresh counter SHALL count clk cycles, wrap at REFRESH-1 and set pending at the wrap.
REQ-025 In IDLE, ser_out_clk, ser_out_rclk and ser_out_dat SHALL be 0.

Reset
REQ-026 While reset is high, the block SHALL be in IDLE with all outputs 0, shift=0, last_sent=0, counters 0 and pending=1.
REQ-027 The first frame after reset release SHALL be transmitted unconditionally.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, without an ser_out_rclk pulse.

Configuration
REQ-029 With macro SER_OUT_REFRESH_EN defined, the refresh counter (REQ-024) SHALL be present.
REQ-030 Without SER_OUT_REFRESH_EN, there SHALL be no refresh counter, REFRESH SHALL be ignored, and frames SHALL start only on pending, force or a data change.

Verification (WIDTH=8, CLK_DIV=2, REFRESH=1000)
REQ-031 Reset release with data_in=8'hA5 -> one 34-cycle frame, dat sequence 1,0,1,0,0,1,0,1 sampled on the clk rising edges, one rclk pulse of 2 cycles, frame_done once.
REQ-032 data_in held at 8'hA5 after the first frame, macro undefined, 5000 cycles -> no further ser_out_clk edges.
REQ-033 Macro defined, data_in constant -> a refresh frame every 1000 cycles with dat pattern unchanged.
REQ-034 data_in changed to 8'h3C at frame cycle 10, plus force pulses at cycles 12 and 14 -> current frame completes with 8'hA5, then exactly one frame with 8'h3C.
REQ-035 reset pulsed at frame cycle 20 -> outputs 0 on the next clk edge, no rclk pulse, a full new frame after release.
REQ-036 force and a data change in the same IDLE cycle -> exactly one frame, busy high for 34 cycles.
